// File: rtl/josh_pkg.sv
// Shared constants and types for the playfield renderer.
// PLAYFIELD_RENDER_BORDER_EN adds the BORDER state to the renderer state enum.
package josh_pkg;

    localparam int unsigned PF_W   = 120;
    localparam int unsigned PF_H   = 100;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned CLR_W  = 3;
    localparam int unsigned BCNT_W = 8;

    localparam logic [CLR_W-1:0] BLACK = 3'b000;
    localparam logic [CLR_W-1:0] WHITE = 3'b111;
    localparam logic [CLR_W-1:0] GREEN = 3'b010;
    localparam logic [CLR_W-1:0] RED   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_DRAW,
`ifdef PLAYFIELD_RENDER_BORDER_EN
        S_BORDER,
`endif
        S_DONE
    } render_state_t;

endpackage

// File: rtl/render_colour_mux.sv
// Priority colour select for one playfield pixel: dude over wall over background.
module render_colour_mux
    import josh_pkg::*;
(
    input  logic             dude_hit,
    input  logic             wall_bit,
    input  logic             dead,
    output logic [CLR_W-1:0] colour_c
);

    // Dude wins, then wall, else black.
    always_comb begin
        colour_c = BLACK;
        if (dude_hit) begin
            colour_c = dead ? RED : GREEN;
        end else if (wall_bit) begin
            colour_c = WHITE;
        end
    end

endmodule

// File: rtl/playfield_renderer.sv
// Sweeps the playfield column by column, overlays the dude and streams pixel writes
// to the VGA adapter. Define PLAYFIELD_RENDER_BORDER_EN to draw a white frame
// border above and below the field after the last column.
module playfield_renderer
    import josh_pkg::*;
#(
    parameter int unsigned X_OFFSET  = 20,
    parameter int unsigned Y_OFFSET  = 10,
    parameter int unsigned FIELD_W   = PF_W,
    parameter int unsigned FIELD_H   = PF_H,
    parameter int unsigned DUDE_SIZE = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [COL_W-1:0] dude_x,
    input  logic [ROW_W-1:0] dude_y,
    input  logic             game_over,
    output logic [COL_W-1:0] col_addr,
    input  logic [PF_H-1:0]  col_data,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [CLR_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic             busy,
    output logic             done
);

`ifdef PLAYFIELD_RENDER_BORDER_EN
    localparam int unsigned BORDER_HALF = FIELD_W + 2;
`endif

    render_state_t    state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] sx_q, sx_d;
    logic [ROW_W-1:0] sy_q, sy_d;
    logic             dead_q, dead_d;
    logic [PF_H-1:0]  buf_q, buf_d;
    logic [X_W-1:0]   x_d;
    logic [Y_W-1:0]   y_d;
    logic [CLR_W-1:0] colour_d;
    logic             plot_d, busy_d, done_d;
`ifdef PLAYFIELD_RENDER_BORDER_EN
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [BCNT_W-1:0] bx;
`endif

    logic [7:0]       col8, row8, sx8, sy8;
    logic             dude_hit;
    logic [CLR_W-1:0] pix_colour_c;

    assign col_addr = col_q;

    // Dude box compare in 8 bits so sx+3 / sy+3 never wraps.
    always_comb begin
        col8     = 8'(col_q);
        row8     = 8'(row_q);
        sx8      = 8'(sx_q);
        sy8      = 8'(sy_q);
        dude_hit = (col8 >= sx8) && (col8 <= sx8 + 8'(DUDE_SIZE - 1)) &&
                   (row8 >= sy8) && (row8 <= sy8 + 8'(DUDE_SIZE - 1));
    end

    render_colour_mux u_colour_mux (
        .dude_hit (dude_hit),
        .wall_bit (buf_q[row_q]),
        .dead     (dead_q),
        .colour_c (pix_colour_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        dead_d   = dead_q;
        buf_d    = buf_q;
        x_d      = vga_x;
        y_d      = vga_y;
        colour_d = vga_colour;
        plot_d   = 1'b0;
        done_d   = 1'b0;
`ifdef PLAYFIELD_RENDER_BORDER_EN
        bcnt_d   = bcnt_q;
        bx       = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sx_d    = dude_x;
                    sy_d    = dude_y;
                    dead_d  = game_over;
                    col_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                buf_d   = col_data;
                row_d   = '0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                plot_d   = 1'b1;
                x_d      = X_W'(X_OFFSET) + X_W'(col_q);
                y_d      = Y_W'(Y_OFFSET + FIELD_H - 1) - row_q;
                colour_d = pix_colour_c;
                if (row_q == ROW_W'(FIELD_H - 1)) begin
                    if (col_q == COL_W'(FIELD_W - 1)) begin
`ifdef PLAYFIELD_RENDER_BORDER_EN
                        bcnt_d  = '0;
                        state_d = S_BORDER;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = S_ADDR;
                    end
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
`ifdef PLAYFIELD_RENDER_BORDER_EN
            S_BORDER: begin
                plot_d   = 1'b1;
                colour_d = WHITE;
                if (bcnt_q < BCNT_W'(BORDER_HALF)) begin
                    bx  = bcnt_q;
                    y_d = Y_W'(Y_OFFSET - 1);
                end else begin
                    bx  = bcnt_q - BCNT_W'(BORDER_HALF);
                    y_d = Y_W'(Y_OFFSET + FIELD_H);
                end
                x_d = X_W'(X_OFFSET - 1) + bx;
                if (bcnt_q == BCNT_W'(2 * BORDER_HALF - 1)) begin
                    state_d = S_DONE;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters, snapshots and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            dead_q     <= 1'b0;
            buf_q      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PLAYFIELD_RENDER_BORDER_EN
            bcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            dead_q     <= dead_d;
            buf_q      <= buf_d;
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef PLAYFIELD_RENDER_BORDER_EN
            bcnt_q     <= bcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_playfield_renderer.sv
// Self-checking bench for playfield_renderer: framebuffer reference model with
// per-pixel colour and cycle expectations derived from the frame geometry.
module tb_playfield_renderer;
    import josh_pkg::*;

`ifdef PLAYFIELD_RENDER_BORDER_EN
    localparam int EXP_PLOTS = 12244;
    localparam int EXP_DONE  = 12485;
`else
    localparam int EXP_PLOTS = 12000;
    localparam int EXP_DONE  = 12241;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  dude_x = '0;
    logic [6:0]  dude_y = '0;
    logic        game_over = 1'b0;
    logic [6:0]  col_addr;
    logic [99:0] col_data = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, done;

    playfield_renderer dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .dude_x     (dude_x),
        .dude_y     (dude_y),
        .game_over  (game_over),
        .col_addr   (col_addr),
        .col_data   (col_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Column memory: one-cycle read latency.
    logic [99:0] walls [120];
    always @(posedge clk) col_data <= (col_addr < 7'd120) ? walls[col_addr] : '0;

    logic [2:0] fb [160][120];
    bit         wr [160][120];

    int checks = 0;
    int passed = 0;
    int n_plots, n_done, done_rel, pix_errs, time_errs, dup_errs, oob_errs;
    int n_green, n_red, first_rel, first_x, first_y;
    int busy_mid, busy_after, plots_after_rst, busy_after_rst;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected colour of adapter pixel (x,y) in a frame with dude snapshot (sx,sy,go).
    function automatic logic [2:0] ref_colour(input int x, input int y,
                                              input int sx, input int sy, input bit go);
        int c = x - 20;
        int r = 109 - y;
        if (c >= 0 && c < 120 && r >= 0 && r < 100) begin
            if (c >= sx && c < sx + 4 && r >= sy && r < sy + 4) return go ? RED : GREEN;
            return walls[c][r] ? WHITE : BLACK;
        end
        return WHITE;
    endfunction

    // Cycle (relative to start sample) at which (x,y) should be written, or -1 if never.
    function automatic int ref_cycle(input int x, input int y);
        int c = x - 20;
        int r = 109 - y;
        if (c >= 0 && c < 120 && r >= 0 && r < 100) return 3 + 102 * c + r;
`ifdef PLAYFIELD_RENDER_BORDER_EN
        if (x >= 19 && x <= 140 && y == 9)   return 12241 + (x - 19);
        if (x >= 19 && x <= 140 && y == 110) return 12363 + (x - 19);
`endif
        return -1;
    endfunction

    task automatic set_walls(input int mode);
        for (int c = 0; c < 120; c++) begin
            case (mode)
                0:       walls[c] = '0;
                1:       walls[c] = (c == 0) ? {100{1'b1}} : '0;
                default: walls[c] = 100'({$urandom, $urandom, $urandom, $urandom});
            endcase
        end
    endtask

    task automatic run_frame(input int sx, input int sy, input bit go, input bit reset_mid);
        int rel, t0, end_rel, x, y, ec;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) begin
                fb[i][j] = '0;
                wr[i][j] = 1'b0;
            end
        n_plots = 0; n_done = 0; done_rel = -1; pix_errs = 0; time_errs = 0;
        dup_errs = 0; oob_errs = 0; n_green = 0; n_red = 0; first_rel = -1;
        first_x = -1; first_y = -1; busy_mid = -1; busy_after = -1;
        plots_after_rst = 0; busy_after_rst = 0;
        @(negedge clk);
        dude_x = 7'(sx); dude_y = 7'(sy); game_over = go; start = 1'b1;
        t0 = edge_cnt + 1;
        end_rel = reset_mid ? 700 : 14000;
        rel = 0;
        while (rel < end_rel) begin
            @(negedge clk);
            rel = edge_cnt - t0;
            if (rel == 0) start = 1'b0;
            if (rel == 5) begin
                game_over = 1'b0;
                dude_x = 7'($urandom_range(119, 0));
                dude_y = 7'($urandom_range(99, 0));
            end
            if (rel == 99 && !reset_mid) start = 1'b1;
            if (rel == 100) start = 1'b0;
            if (reset_mid && rel == 499) resetn = 1'b0;
            if (rel == 500) resetn = 1'b1;
            if (rel == 50) busy_mid = int'(busy);
            if (reset_mid && rel >= 501 && busy) busy_after_rst++;
            if (vga_plot) begin
                n_plots++;
                if (first_rel < 0) begin
                    first_rel = rel; first_x = int'(vga_x); first_y = int'(vga_y);
                end
                if (reset_mid && rel >= 501) plots_after_rst++;
                x = int'(vga_x); y = int'(vga_y);
                if (x > 159 || y > 119) oob_errs++;
                else begin
                    ec = ref_cycle(x, y);
                    if (ec < 0) oob_errs++;
                    else begin
                        if (wr[x][y]) dup_errs++;
                        wr[x][y] = 1'b1;
                        fb[x][y] = vga_colour;
                        if (rel != ec) time_errs++;
                        if (vga_colour != ref_colour(x, y, sx, sy, go)) pix_errs++;
                        if (vga_colour == GREEN) n_green++;
                        if (vga_colour == RED) n_red++;
                    end
                end
            end
            if (done) begin
                n_done++;
                done_rel = rel;
            end
            if (done_rel >= 0 && rel == done_rel + 5) busy_after = int'(busy);
            if (done_rel >= 0 && rel >= done_rel + 150) break;
        end
        start = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input int exp_g, input int exp_r);
        check({tag, " plot count"}, n_plots, EXP_PLOTS);
        check({tag, " done cycle"}, done_rel, EXP_DONE);
        check({tag, " done pulses"}, n_done, 1);
        check({tag, " colour errors"}, pix_errs, 0);
        check({tag, " timing errors"}, time_errs, 0);
        check({tag, " duplicate writes"}, dup_errs, 0);
        check({tag, " out-of-range writes"}, oob_errs, 0);
        check({tag, " green pixels"}, n_green, exp_g);
        check({tag, " red pixels"}, n_red, exp_r);
        check({tag, " first plot cycle"}, first_rel, 3);
        check({tag, " first plot x"}, first_x, 20);
        check({tag, " first plot y"}, first_y, 109);
        check({tag, " busy mid-frame"}, busy_mid, 1);
        check({tag, " busy after done"}, busy_after, 0);
    endtask

    function automatic int dude_area(input int sx, input int sy);
        return ((sx > 116) ? 120 - sx : 4) * ((sy > 96) ? 100 - sy : 4);
    endfunction

    typedef struct {
        int dx; int dy; bit go; int wmode;
        int exp_g; int exp_r;
        int px; int py; int pcol;
    } vec_t;

    initial begin
        vec_t vecs[3];
        int sx, sy;
        vecs[0] = '{dx: 20,  dy: 6,  go: 1'b0, wmode: 0, exp_g: 16, exp_r: 0, px: 40,  py: 100, pcol: 2};
        vecs[1] = '{dx: 60,  dy: 50, go: 1'b0, wmode: 1, exp_g: 16, exp_r: 0, px: 20,  py: 10,  pcol: 7};
        vecs[2] = '{dx: 118, dy: 98, go: 1'b0, wmode: 0, exp_g: 4,  exp_r: 0, px: 139, py: 10,  pcol: 2};

        // Reset values, with start held high during reset.
        set_walls(0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset vga_plot", int'(vga_plot), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset vga_x", int'(vga_x), 0);
        check("reset vga_y", int'(vga_y), 0);
        check("reset vga_colour", int'(vga_colour), 0);
        check("reset col_addr", int'(col_addr), 0);
        start = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            set_walls(vecs[v].wmode);
            run_frame(vecs[v].dx, vecs[v].dy, vecs[v].go, 1'b0);
            frame_checks($sformatf("vec%0d", v), vecs[v].exp_g, vecs[v].exp_r);
            check($sformatf("vec%0d probe pixel", v), int'(fb[vecs[v].px][vecs[v].py]), vecs[v].pcol);
`ifdef PLAYFIELD_RENDER_BORDER_EN
            check($sformatf("vec%0d border top-left", v), int'(fb[19][9]), 7);
            check($sformatf("vec%0d border bottom-right", v), int'(fb[140][110]), 7);
`endif
            repeat (3) @(negedge clk);
        end

        // Dead dude: game_over dropped mid-frame, extra start ignored.
        set_walls(2);
        run_frame(0, 0, 1'b1, 1'b0);
        frame_checks("dead", 0, 16);
        check("dead probe pixel", int'(fb[20][109]), 4);
        repeat (3) @(negedge clk);

        // Synchronous reset mid-frame, then a fresh frame from column 0.
        set_walls(2);
        run_frame(30, 40, 1'b0, 1'b1);
        check("reset-mid plots after reset", plots_after_rst, 0);
        check("reset-mid busy after reset", busy_after_rst, 0);
        check("reset-mid done pulses", n_done, 0);
        repeat (3) @(negedge clk);

        sx = $urandom_range(119, 0);
        sy = $urandom_range(99, 0);
        set_walls(2);
        run_frame(sx, sy, 1'b0, 1'b0);
        frame_checks("random", dude_area(sx, sy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/playfield_renderer.md
# playfield_renderer

Downstream of the game datapath, ahead of the VGA adapter. On each frame-start pulse it sweeps the 120×100 playfield one column at a time. Each column's wall bits come from the datapath's column read port, and the dude is overlaid as a 4×4 box. The block emits one pixel write per cycle (x, y, colour, plot) into the 160×120 adapter framebuffer, then pulses `done` so the game can advance its next tick.

## Interface
Parameters:
- `X_OFFSET`, 20: adapter x of playfield column 0
- `Y_OFFSET`, 10: adapter y of playfield top row (row 99)
- `FIELD_W`, 120: playfield columns
- `FIELD_H`, 100: playfield rows
- `DUDE_SIZE`, 4: dude box edge in pixels

Ports:
- `clk` in 1: system clock (CLOCK_50)
- `resetn` in 1: synchronous reset, active-low
- `start` in 1: frame-start request pulse
- `dude_x` in 7: dude left column, 0..119
- `dude_y` in 7: dude bottom row, 0..99
- `game_over` in 1: dude drawn in dead colour
- `col_addr` out 7: wall column read address
- `col_data` in 100: wall bits of column `col_addr`, bit r = row r; valid one cycle after address
- `vga_x` out 8: adapter x
- `vga_y` out 7: adapter y
- `vga_colour` out 3: RGB
- `vga_plot` out 1: write strobe
- `busy` out 1: frame in progress
- `done` out 1: one-cycle frame-complete pulse

## Operation
- States: IDLE, ADDR, CAPTURE, DRAW, (BORDER), DONE.
- **IDLE:** if `start`=1, latch `dude_x`, `dude_y` and `game_over` into snapshot registers, clear the column counter to 0, and go to ADDR. Otherwise stay in IDLE.
- **ADDR:** `col_addr` = column counter. It is held stable for the whole column, and the state lasts one cycle.
- **CAPTURE:** `col_data` is valid and is latched into a 100-bit column buffer. Clear the row counter and go to DRAW.
- **DRAW:** one pixel per cycle with `vga_plot`=1, for rows 0..99.
  - `vga_x` = `X_OFFSET` + col.
  - `vga_y` = `Y_OFFSET` + (`FIELD_H`−1−row). Row 0 is at the bottom.
  - After row 99: if col < 119, increment col and go to ADDR; otherwise go to BORDER if compiled in, else DONE.
- **Colour priority:**
  - Dude pixel (col ∈ [sx, sx+3] and row ∈ [sy, sy+3]): red 3'b100 if the game_over snapshot is set, else green 3'b010.
  - Else wall bit = 1: white 3'b111.
  - Else black 3'b000.
- **Arithmetic:** dude range compares are 8 bits wide (no 7-bit wrap). Parts of the dude beyond column 119 or row 99 are clipped.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while `busy` is ignored and is not queued.
- Inputs that change mid-frame have no effect; the snapshot rule prevents tearing.
- Reset mid-frame: next state is IDLE, every output is deasserted, and no further plots occur.

## Timing
- Reset values: `vga_plot`=0, `busy`=0, `done`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `col_addr`=0.
- All outputs are registered or decoded from registered state. No combinational path from `start` to `vga_plot`.
- Cycle 0 is the edge at which `start` is sampled.
- Column c, row r plots in cycle 3 + 102c + r.
- First plot: cycle 3, x=20, y=109.
- Last column plot: cycle 12240.
- `done` timing:
  - Without border: cycle 12241.
  - With border: cycle 12485.
- `start` is sampled again from the cycle after `done`.

## Configuration
- `PLAYFIELD_RENDER_BORDER_EN` defined:
  - After column 119, the BORDER state plots 244 white pixels, one per cycle, for x = 19..140.
  - First the top row, y=9 (122 pixels), then the bottom row, y=110 (122 pixels).
  - Then DONE.
- Undefined: the BORDER state and its counter are absent, and DRAW goes directly to DONE.

## Structure
- Package `josh_pkg`:
  - colour constants (BLACK, WHITE, GREEN, RED)
  - playfield dimension constants
  - renderer state enum
- One sub-module, `render_colour_mux`: combinational priority select from the dude-hit compare, wall bit and game_over snapshot, producing colour.
- Counters and FSM live in the top module.

## Test plan
- Empty walls, dude (20,6), `start` pulse:
  - exactly 12000 plots; `done` at cycle 12241
  - green only at x 40..43, y 100..103; all other pixels black
- Column 0 = all-ones, other columns zero: x=20 is white for y 10..109; first plot is at cycle 3 with y=109.
- Dude (118,98): green only at x 138..139, y 10..11. Clipped; no write outside x 20..139 or y 10..109.
- `game_over`=1 at start, dropped after cycle 5: the whole frame's dude pixels are red. A second `start` at cycle 100 is ignored (single `done`).
- `resetn` low at cycle 500 for one cycle: `vga_plot`/`busy` are 0 from cycle 501. A fresh `start` restarts at column 0.
- `PLAYFIELD_RENDER_BORDER_EN` build, empty walls:
  - 12244 plots; `done` at cycle 12485
  - pixels (19,9) and (140,110) are white
